// File: rtl/tics_module.sv
// -----------------------------------------------------------------------------
// tics_module
//
// Single-bit storage cell modelling a MOS-style flop with true and
// complement outputs.  Four single-bit pattern inputs give a D-load path
// plus JK-style set / clear / hold / toggle control.
//
// Next-state priority on each rising clk edge (effective inputs):
//   in_3 = 1                 : q <= in_7      (load beats J/K)
//   in_3 = 0, in_5=0, in_4=0 : hold
//   in_3 = 0, in_5=1, in_4=0 : set
//   in_3 = 0, in_5=0, in_4=1 : clear
//   in_3 = 0, in_5=1, in_4=1 : toggle
//
// Ports:
//   clk    in   single clock, rising-edge active
//   rst_n  in   asynchronous active-low reset (q -> 0, qbar -> 1)
//   in_5   in   J / set request         (pattern vector bit 3)
//   in_4   in   K / clear request       (pattern vector bit 2)
//   in_7   in   D data                  (pattern vector bit 1)
//   in_3   in   load enable, D path     (pattern vector bit 0)
//   out_2  out  q, stored state (taken straight from the state flop)
//   out_6  out  qbar, always the complement of out_2
//
// Optional build macro:
//   TICS_INPUT_SYNC_EN - when defined, every control input passes through a
//                        2-flop synchronizer (reset to 0) before the
//                        next-state logic, so inputs may be asynchronous to
//                        clk and the input-to-output latency grows from 1 to
//                        3 cycles.  When undefined, inputs feed the
//                        next-state logic directly with no extra flops.
// -----------------------------------------------------------------------------
module tics_module (
  input  logic clk,
  input  logic rst_n,
  input  logic in_5,
  input  logic in_4,
  input  logic in_7,
  input  logic in_3,
  output logic out_2,
  output logic out_6
);

  // Effective control inputs seen by the next-state logic.
  logic j_eff;
  logic k_eff;
  logic d_eff;
  logic ld_eff;

  // Stored bit and its next value.
  logic q_q;
  logic q_d;

`ifdef TICS_INPUT_SYNC_EN
  // Two synchronizer stages, packed as {J, K, D, LD}.
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  // Two-flop input synchronizer; both stages clear on reset so that no
  // pre-reset history can reach the state flop afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= {in_5, in_4, in_7, in_3};
      sync2_q <= sync1_q;
    end
  end

  assign j_eff  = sync2_q[3];
  assign k_eff  = sync2_q[2];
  assign d_eff  = sync2_q[1];
  assign ld_eff = sync2_q[0];
`else
  assign j_eff  = in_5;
  assign k_eff  = in_4;
  assign d_eff  = in_7;
  assign ld_eff = in_3;
`endif

  // Next-state logic.  Written as a pure gate equation rather than an
  // if/case tree so that an X/Z on any control input propagates to q in
  // simulation instead of being silently steered into one branch.
  //   JK part : q+ = J & ~q | ~K & q   (hold, set, clear, toggle)
  //   load    : overrides JK when ld is high.
  always_comb begin
    q_d = (ld_eff & d_eff)
        | (~ld_eff & ((j_eff & ~q_q) | (~k_eff & q_q)));
  end

  // State flop; asynchronous reset forces q low immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  // Both outputs come from the same flop, so they can never be equal,
  // including while reset is asserted.
  assign out_2 = q_q;
  assign out_6 = ~q_q;

endmodule

// File: tb/tb_tics_module.sv
// -----------------------------------------------------------------------------
// tb_tics_module
//
// Self-checking bench for tics_module.  Vectors are written as
// {in_5, in_4, in_7, in_3} (MSB first).  Table-driven vectors cover load,
// set/clear/hold and toggle; hand-written sequences cover asynchronous reset
// and (in the synchronizer build) the 3-cycle latency and history clearing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tics_module;

  logic clk;
  logic rst_n;
  logic in_5;
  logic in_4;
  logic in_7;
  logic in_3;
  logic out_2;
  logic out_6;

  int total;
  int bad;

  tics_module dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in_5  (in_5),
    .in_4  (in_4),
    .in_7  (in_7),
    .in_3  (in_3),
    .out_2 (out_2),
    .out_6 (out_6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vec;
    logic       exp_q;
    string      name;
  } vec_t;

  vec_t tbl [0:13];

  task automatic apply(input logic [3:0] v);
    in_5 = v[3];
    in_4 = v[2];
    in_7 = v[1];
    in_3 = v[0];
  endtask

  task automatic check(input string name, input logic exp_q);
    total = total + 1;
    if (out_2 !== exp_q) begin
      bad = bad + 1;
      $display("FAIL %s out_2: got %b want %b", name, out_2, exp_q);
    end
    total = total + 1;
    if (out_6 !== ~exp_q) begin
      bad = bad + 1;
      $display("FAIL %s out_6: got %b want %b", name, out_6, ~exp_q);
    end
  endtask

  // Drive a vector at the falling edge, then sample 1 ns after the next
  // rising edge.
  task automatic step(input logic [3:0] v);
    @(negedge clk);
    apply(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Hand-computed expectations; the cell starts at q = 0 after reset.
    tbl[0]  = '{4'b0011, 1'b1, "load1"};
    tbl[1]  = '{4'b0001, 1'b0, "load0"};
    tbl[2]  = '{4'b0011, 1'b1, "load1_again"};
    tbl[3]  = '{4'b1101, 1'b0, "load_beats_jk"};
    tbl[4]  = '{4'b1000, 1'b1, "set"};
    tbl[5]  = '{4'b0000, 1'b1, "hold1"};
    tbl[6]  = '{4'b0100, 1'b0, "clear"};
    tbl[7]  = '{4'b0000, 1'b0, "hold0"};
    tbl[8]  = '{4'b1100, 1'b1, "toggle1"};
    tbl[9]  = '{4'b1100, 1'b0, "toggle2"};
    tbl[10] = '{4'b1100, 1'b1, "toggle3"};
    tbl[11] = '{4'b1100, 1'b0, "toggle4"};
    tbl[12] = '{4'b0111, 1'b1, "load1_with_k"};
    tbl[13] = '{4'b1110, 1'b0, "toggle_d_ignored"};

    // Reset asserted with all inputs high, no clock edge needed.
    apply(4'b1111);
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async", 1'b0);

    // Release with 0000 held; outputs stay 0/1.
    @(negedge clk);
    apply(4'b0000);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_release", 1'b0);

`ifndef TICS_INPUT_SYNC_EN
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].vec);
      check(tbl[i].name, tbl[i].exp_q);
    end

    // Mid-run reset: load a 1, then pulse reset between edges.
    step(4'b0011);
    check("pre_reset_q1", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'b0011);
    @(posedge clk);
    #1;
    check("first_edge_after_reset", 1'b1);
`else
    // From reset, apply 1000 before edge 1; q rises only after edge 3.
    @(negedge clk);
    apply(4'b1000);
    @(posedge clk);
    #1;
    check("sync_edge1", 1'b0);
    @(posedge clk);
    #1;
    check("sync_edge2", 1'b0);
    @(posedge clk);
    #1;
    check("sync_edge3", 1'b1);

    // Reset pulse with 1000 still applied; history must be wiped.
    #2;
    rst_n = 1'b0;
    #1;
    check("sync_midrun_reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'b0000);
    repeat (3) @(posedge clk);
    #1;
    check("sync_history_cleared", 1'b0);

    // Load path through the synchronizer, 3-cycle latency.
    @(negedge clk);
    apply(4'b0011);
    repeat (2) @(posedge clk);
    #1;
    check("sync_load_edge2", 1'b0);
    @(posedge clk);
    #1;
    check("sync_load_edge3", 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
